div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV/DIVU, one quotient bit per cycle.
// Result is {remainder, quotient}. Optional build macro DIV_ZERO_DIVIDEND_FAST_EN
// routes a zero dividend through the BYZERO fast path instead of the full loop.
//
// state  | meaning
// FREE   | idle, waiting for start_i (blocked while annul_i=1)
// BYZERO | zero divisor (or fast zero dividend), result forced to 0
// ON     | one shift-subtract step per cycle, DIV_W steps
// END    | result valid, held while start_i stays high
module div_unit #(
  parameter int DIV_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 signed_div_i,
  input  logic [DIV_W-1:0]     opdata1_i,
  input  logic [DIV_W-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*DIV_W-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DIV_W-1:0]    rem;
  logic [DIV_W-1:0]    dvd;
  logic [DIV_W-1:0]    dsr;
  logic                signed_r;
  logic                sign1_r;
  logic                sign2_r;
  logic [2*DIV_W-1:0]  result_r;

  logic                accept;
  logic                fast_zero;
  logic                last_step;
  logic [DIV_W:0]      shifted;
  logic [DIV_W:0]      diff;
  logic                borrow;
  logic                qbit;
  logic [DIV_W-1:0]    rem_nxt;
  logic [DIV_W-1:0]    quo_nxt;
  logic [DIV_W-1:0]    rem_fix;
  logic [DIV_W-1:0]    quo_fix;
  logic                unused_diff_msb;

`ifdef DIV_ZERO_DIVIDEND_FAST_EN
  assign fast_zero = (opdata1_i == '0);
`else
  assign fast_zero = 1'b0;
`endif

  assign accept    = start_i && !annul_i;
  assign last_step = (cnt == CNT_W'(DIV_W - 1));

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // The quotient bits shift into the low end of dvd as dividend bits leave the top.
  always_comb begin
    shifted         = {rem, dvd[DIV_W-1]};
    {borrow, diff}  = {1'b0, shifted} - {2'b00, dsr};
    qbit            = ~borrow;
    // With no borrow the difference is below the divisor, so its top bit is always 0.
    unused_diff_msb = diff[DIV_W];
    rem_nxt         = qbit ? diff[DIV_W-1:0] : shifted[DIV_W-1:0];
    quo_nxt         = {dvd[DIV_W-2:0], qbit};
    quo_fix         = (signed_r && (sign1_r ^ sign2_r)) ? (~quo_nxt + 1'b1) : quo_nxt;
    rem_fix         = (signed_r && sign1_r) ? (~rem_nxt + 1'b1) : rem_nxt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FREE;
    else     state <= state_nxt;
  end

  // Next-state logic and outputs; result is only exposed in END.
  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    busy_o    = 1'b0;
    result_o  = '0;
    case (state)
      FREE: begin
        if (accept) begin
          if (opdata2_i == '0 || fast_zero) state_nxt = BYZERO;
          else                              state_nxt = ON;
        end
      end
      BYZERO: begin
        busy_o    = 1'b1;
        state_nxt = annul_i ? FREE : END;
      end
      ON: begin
        busy_o = 1'b1;
        if (annul_i)        state_nxt = FREE;
        else if (last_step) state_nxt = END;
      end
      END: begin
        ready_o  = 1'b1;
        result_o = result_r;
        if (!start_i) state_nxt = FREE;
      end
      default: state_nxt = FREE;
    endcase
  end

  // Operand latch and iteration datapath; magnitudes are taken at latch time.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      signed_r <= 1'b0;
      sign1_r  <= 1'b0;
      sign2_r  <= 1'b0;
      result_r <= '0;
    end else begin
      case (state)
        FREE: begin
          if (accept) begin
            signed_r <= signed_div_i;
            sign1_r  <= opdata1_i[DIV_W-1];
            sign2_r  <= opdata2_i[DIV_W-1];
            dvd      <= (signed_div_i && opdata1_i[DIV_W-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
            dsr      <= (signed_div_i && opdata2_i[DIV_W-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
            rem      <= '0;
            cnt      <= '0;
            result_r <= '0;
          end
        end
        ON: begin
          rem <= rem_nxt;
          dvd <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (last_step) result_r <= {rem_fix, quo_fix};
        end
        default: ;
      endcase
    end
  end

endmodule
